// File: rtl/atm_dut_if.sv
// -----------------------------------------------------------------------------
// atm_dut_if
// Front-panel / cash-mechanism signal bundle for the ATM transaction controller.
//   card     : level, 1 = card present
//   PIN      : 1 = correct PIN confirmed
//   choice   : 0 = withdraw, 1 = deposit
//   amount   : 00 = 1 unit, 01 = 2 units, 10 = 4 units, 11 = cancel
//   W_*      : one-cycle dispense pulses (controller -> cash mechanism)
//   D_*      : one-cycle accept pulses   (controller -> cash mechanism)
// slave  modport: the controller side.
// master modport: the panel / mechanism side driving inputs, observing pulses.
// -----------------------------------------------------------------------------
interface atm_dut_if;
  logic       card;
  logic       PIN;
  logic       choice;
  logic [1:0] amount;
  logic       W_50000;
  logic       W_100000;
  logic       W_200000;
  logic       D_50000;
  logic       D_100000;
  logic       D_200000;

  modport slave (
    input  card, PIN, choice, amount,
    output W_50000, W_100000, W_200000, D_50000, D_100000, D_200000
  );

  modport master (
    output card, PIN, choice, amount,
    input  W_50000, W_100000, W_200000, D_50000, D_100000, D_200000
  );
endinterface

// File: rtl/atm_dut.sv
// -----------------------------------------------------------------------------
// atm_dut
// Single-account ATM transaction controller. Sequences card insertion, PIN
// confirmation, withdraw/deposit choice and denomination selection, keeps a
// balance in units of 50000 and emits one registered pulse per successful
// transaction.
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : atm_dut_if.slave (card, PIN, choice, amount in; W_*/D_* out)
// Parameters:
//   BAL_W        balance width in units (must be >= 3)
//   INIT_BALANCE balance loaded at reset
//   PIN_TIMEOUT  cycles allowed in PIN_WAIT before the card is rejected
// -----------------------------------------------------------------------------
module atm_dut #(
  parameter int BAL_W        = 8,
  parameter int INIT_BALANCE = 4,
  parameter int PIN_TIMEOUT  = 16
) (
  input  logic      clock,
  input  logic      reset,
  atm_dut_if.slave  bus
);

  localparam int TMR_W = (PIN_TIMEOUT > 1) ? $clog2(PIN_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PIN_WAIT = 3'd1,
    SELECT   = 3'd2,
    AMOUNT   = 3'd3,
    DONE     = 3'd4,
    EJECT    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               op_q, op_d;
  logic [BAL_W-1:0]   bal_q, bal_d;
  // Output pulse vector: {W_50000, W_100000, W_200000, D_50000, D_100000, D_200000}
  logic [5:0]         out_q, out_d;

  // Denomination code to balance units; cancel code maps to 0 and is never used.
  function automatic logic [BAL_W-1:0] amount_units(input logic [1:0] amt);
    case (amt)
      2'b00:   amount_units = BAL_W'(1);
      2'b01:   amount_units = BAL_W'(2);
      2'b10:   amount_units = BAL_W'(4);
      default: amount_units = '0;
    endcase
  endfunction

  function automatic logic can_withdraw(input logic [BAL_W-1:0] bal,
                                        input logic [BAL_W-1:0] units);
    can_withdraw = (bal >= units);
  endfunction

  // Sum is formed one bit wider so a carry out flags overflow.
  function automatic logic can_deposit(input logic [BAL_W-1:0] bal,
                                       input logic [BAL_W-1:0] units);
    logic [BAL_W:0] sum;
    sum         = {1'b0, bal} + {1'b0, units};
    can_deposit = ~sum[BAL_W];
  endfunction

  function automatic logic [5:0] pulse_vec(input logic op, input logic [1:0] amt);
    logic [5:0] v;
    v = '0;
    case ({op, amt})
      3'b000:  v[5] = 1'b1;
      3'b001:  v[4] = 1'b1;
      3'b010:  v[3] = 1'b1;
      3'b100:  v[2] = 1'b1;
      3'b101:  v[1] = 1'b1;
      3'b110:  v[0] = 1'b1;
      default: v    = '0;
    endcase
    pulse_vec = v;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      op_q    <= 1'b0;
      bal_q   <= BAL_W'(INIT_BALANCE);
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      op_q    <= op_d;
      bal_q   <= bal_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    op_d    = op_q;
    bal_d   = bal_q;
    out_d   = '0;
    case (state_q)
      IDLE: begin
        if (bus.card) begin
          state_d = PIN_WAIT;
          timer_d = '0;
        end
      end
      PIN_WAIT: begin
        if (!bus.card)                                state_d = IDLE;
        else if (bus.PIN)                             state_d = SELECT;
        else if (timer_q == TMR_W'(PIN_TIMEOUT - 1))  state_d = EJECT;
        else                                          timer_d = timer_q + 1'b1;
      end
      SELECT: begin
        if (!bus.card) begin
          state_d = IDLE;
        end else begin
          op_d    = bus.choice;
          state_d = AMOUNT;
        end
      end
      AMOUNT: begin
        if (!bus.card) begin
          state_d = IDLE;
        end else if (bus.amount == 2'b11) begin
          state_d = EJECT;
        end else if (!op_q) begin
          if (can_withdraw(bal_q, amount_units(bus.amount))) begin
            state_d = DONE;
            bal_d   = bal_q - amount_units(bus.amount);
            out_d   = pulse_vec(op_q, bus.amount);
          end else begin
            state_d = EJECT;
          end
        end else begin
          if (can_deposit(bal_q, amount_units(bus.amount))) begin
            state_d = DONE;
            bal_d   = bal_q + amount_units(bus.amount);
            out_d   = pulse_vec(op_q, bus.amount);
          end else begin
            state_d = EJECT;
          end
        end
      end
      // The pulse is already on the outputs; card removal here only skips EJECT.
      DONE:    state_d = bus.card ? EJECT : IDLE;
      EJECT:   if (!bus.card) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.W_50000  = out_q[5];
  assign bus.W_100000 = out_q[4];
  assign bus.W_200000 = out_q[3];
  assign bus.D_50000  = out_q[2];
  assign bus.D_100000 = out_q[1];
  assign bus.D_200000 = out_q[0];

endmodule

// File: tb/tb_atm_dut.sv
// -----------------------------------------------------------------------------
// tb_atm_dut
// Scenario-driven bench for atm_dut. A small reference model tracks the
// balance; expected pulse vectors are queued when the amount is driven and
// popped when the outputs are sampled.
// -----------------------------------------------------------------------------
module tb_atm_dut;

  localparam int BAL_W        = 8;
  localparam int INIT_BALANCE = 4;
  localparam int PIN_TIMEOUT  = 16;
  localparam int BAL_MAX      = (1 << BAL_W) - 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PIN_WAIT = 3'd1;
  localparam logic [2:0] S_AMOUNT   = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_EJECT    = 3'd5;

  logic clock = 1'b0;
  logic reset = 1'b0;

  atm_dut_if bus ();

  atm_dut #(
    .BAL_W(BAL_W),
    .INIT_BALANCE(INIT_BALANCE),
    .PIN_TIMEOUT(PIN_TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int         total = 0;
  int         bad   = 0;
  int         model_bal;
  logic [5:0] exp_q[$];
  logic [2:0] exp_st_q[$];

  function automatic logic [5:0] outs();
    return {bus.W_50000, bus.W_100000, bus.W_200000,
            bus.D_50000, bus.D_100000, bus.D_200000};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.card = 1'b0; bus.PIN = 1'b0; bus.choice = 1'b0; bus.amount = 2'b00;
    repeat (2) tick();
    reset = 1'b1;
    model_bal = INIT_BALANCE;
    exp_q.delete();
    exp_st_q.delete();
  endtask

  // Reference model: expected pulse vector and state after the AMOUNT edge.
  task automatic model_push(input logic ch, input logic [1:0] amt);
    int         units;
    logic [5:0] v;
    logic [2:0] s;
    units = (amt == 2'b00) ? 1 : (amt == 2'b01) ? 2 : 4;
    v = '0;
    s = S_EJECT;
    if (amt != 2'b11) begin
      if (!ch && model_bal >= units) begin
        model_bal -= units;
        v = 6'b100000 >> amt;
        s = S_DONE;
      end else if (ch && model_bal + units <= BAL_MAX) begin
        model_bal += units;
        v = 6'b000100 >> amt;
        s = S_DONE;
      end
    end
    exp_q.push_back(v);
    exp_st_q.push_back(s);
  endtask

  // Card at edge k, PIN at k+1, choice at k+2, amount at k+3; samples right after k+3.
  task automatic drive_txn(input logic ch, input logic [1:0] amt,
                           output logic [5:0] got, output logic [2:0] st);
    bus.card = 1'b1; bus.PIN = 1'b0;
    tick();
    bus.PIN = 1'b1;
    tick();
    bus.PIN = 1'b0; bus.choice = ch;
    tick();
    bus.amount = amt;
    model_push(ch, amt);
    tick();
    got = outs();
    st  = dut.state_q;
  endtask

  task automatic end_txn();
    tick();
    bus.card = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (outs() !== 6'b0) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs(), 6'b0); end
    total++; if (dut.bal_q !== BAL_W'(INIT_BALANCE)) begin bad++; $display("FAIL reset_bal got=%0d exp=%0d", dut.bal_q, INIT_BALANCE); end
    total++; if (dut.state_q !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, S_IDLE); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (outs() !== 6'b0) begin bad++; $display("FAIL idle_outs cyc=%0d got=%b exp=%b", i, outs(), 6'b0); end
    end
  endtask

  task automatic test_withdraw();
    logic [5:0] got, e; logic [2:0] st, es;
    drive_txn(1'b0, 2'b01, got, st);
    e = exp_q.pop_front(); es = exp_st_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL wd100k_pulse got=%b exp=%b", got, e); end
    total++; if (st !== es) begin bad++; $display("FAIL wd100k_state got=%0d exp=%0d", st, es); end
    total++; if (dut.bal_q !== BAL_W'(model_bal)) begin bad++; $display("FAIL wd100k_bal got=%0d exp=%0d", dut.bal_q, model_bal); end
    tick();
    total++; if (outs() !== 6'b0) begin bad++; $display("FAIL wd100k_one_cycle got=%b exp=%b", outs(), 6'b0); end
    total++; if (dut.state_q !== S_EJECT) begin bad++; $display("FAIL wd100k_eject got=%0d exp=%0d", dut.state_q, S_EJECT); end
    bus.card = 1'b0;
    tick();
    total++; if (dut.state_q !== S_IDLE) begin bad++; $display("FAIL wd100k_idle got=%0d exp=%0d", dut.state_q, S_IDLE); end
  endtask

  task automatic test_insufficient();
    logic [5:0] got, e; logic [2:0] st, es;
    do_reset();
    drive_txn(1'b0, 2'b10, got, st);
    e = exp_q.pop_front(); es = exp_st_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL wd200k_pulse got=%b exp=%b", got, e); end
    end_txn();
    drive_txn(1'b0, 2'b00, got, st);
    e = exp_q.pop_front(); es = exp_st_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL nsf_pulse got=%b exp=%b", got, e); end
    total++; if (st !== es) begin bad++; $display("FAIL nsf_state got=%0d exp=%0d", st, es); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (dut.state_q !== S_EJECT || outs() !== 6'b0) begin bad++; $display("FAIL nsf_hold cyc=%0d state=%0d outs=%b exp_state=%0d", i, dut.state_q, outs(), S_EJECT); end
    end
    total++; if (dut.bal_q !== BAL_W'(model_bal)) begin bad++; $display("FAIL nsf_bal got=%0d exp=%0d", dut.bal_q, model_bal); end
    bus.card = 1'b0;
    tick();
    total++; if (dut.state_q !== S_IDLE) begin bad++; $display("FAIL nsf_idle got=%0d exp=%0d", dut.state_q, S_IDLE); end
  endtask

  task automatic test_deposit();
    logic [5:0] got, e; logic [2:0] st, es;
    drive_txn(1'b1, 2'b10, got, st);
    e = exp_q.pop_front(); es = exp_st_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL dep200k_pulse got=%b exp=%b", got, e); end
    total++; if (dut.bal_q !== BAL_W'(model_bal)) begin bad++; $display("FAIL dep200k_bal got=%0d exp=%0d", dut.bal_q, model_bal); end
    tick();
    total++; if (outs() !== 6'b0) begin bad++; $display("FAIL dep200k_one_cycle got=%b exp=%b", outs(), 6'b0); end
    bus.card = 1'b0;
    tick();
    drive_txn(1'b0, 2'b10, got, st);
    e = exp_q.pop_front(); es = exp_st_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL dep_then_wd_pulse got=%b exp=%b", got, e); end
    end_txn();
  endtask

  task automatic test_timeout();
    bus.card = 1'b1; bus.PIN = 1'b0;
    tick();
    for (int i = 0; i < PIN_TIMEOUT - 1; i++) begin
      tick();
      total++; if (dut.state_q !== S_PIN_WAIT || outs() !== 6'b0) begin bad++; $display("FAIL pin_wait cyc=%0d state=%0d outs=%b exp_state=%0d", i, dut.state_q, outs(), S_PIN_WAIT); end
    end
    tick();
    total++; if (dut.state_q !== S_EJECT || outs() !== 6'b0) begin bad++; $display("FAIL pin_timeout state=%0d outs=%b exp_state=%0d", dut.state_q, outs(), S_EJECT); end
    bus.card = 1'b0;
    tick();
  endtask

  task automatic test_cancel();
    logic [5:0] got, e; logic [2:0] st, es;
    drive_txn(1'b1, 2'b00, got, st);
    e = exp_q.pop_front(); es = exp_st_q.pop_front();
    end_txn();
    drive_txn(1'b0, 2'b11, got, st);
    e = exp_q.pop_front(); es = exp_st_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL cancel_pulse got=%b exp=%b", got, e); end
    total++; if (st !== es) begin bad++; $display("FAIL cancel_state got=%0d exp=%0d", st, es); end
    total++; if (dut.bal_q !== BAL_W'(model_bal)) begin bad++; $display("FAIL cancel_bal got=%0d exp=%0d", dut.bal_q, model_bal); end
    end_txn();
  endtask

  task automatic test_back_to_back();
    logic [5:0] got, e; logic [2:0] st, es;
    logic [1:0] amts[3] = '{2'b01, 2'b00, 2'b01};
    logic       chs[3]  = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive_txn(chs[i], amts[i], got, st);
      e = exp_q.pop_front(); es = exp_st_q.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL b2b_pulse txn=%0d got=%b exp=%b", i, got, e); end
      end_txn();
    end
    total++; if (dut.bal_q !== BAL_W'(model_bal)) begin bad++; $display("FAIL b2b_bal got=%0d exp=%0d", dut.bal_q, model_bal); end
  endtask

  // Fill towards the top of the balance range, then overflow by one unit.
  task automatic test_overflow();
    logic [5:0] got, e; logic [2:0] st, es;
    logic [1:0] amt;
    while (model_bal < BAL_MAX) begin
      amt = (BAL_MAX - model_bal >= 4) ? 2'b10 : (BAL_MAX - model_bal >= 2) ? 2'b01 : 2'b00;
      drive_txn(1'b1, amt, got, st);
      e = exp_q.pop_front(); es = exp_st_q.pop_front();
      total++; if (got !== e) begin bad++; $display("FAIL fill_pulse bal=%0d got=%b exp=%b", model_bal, got, e); end
      end_txn();
    end
    total++; if (dut.bal_q !== BAL_W'(BAL_MAX)) begin bad++; $display("FAIL full_bal got=%0d exp=%0d", dut.bal_q, BAL_MAX); end
    drive_txn(1'b1, 2'b00, got, st);
    e = exp_q.pop_front(); es = exp_st_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL ovf_pulse got=%b exp=%b", got, e); end
    total++; if (st !== es) begin bad++; $display("FAIL ovf_state got=%0d exp=%0d", st, es); end
    total++; if (dut.bal_q !== BAL_W'(model_bal)) begin bad++; $display("FAIL ovf_bal got=%0d exp=%0d", dut.bal_q, model_bal); end
    end_txn();
  endtask

  task automatic test_abort_card();
    bus.card = 1'b1; bus.PIN = 1'b0;
    tick();
    bus.PIN = 1'b1;
    tick();
    bus.PIN = 1'b0; bus.choice = 1'b0;
    tick();
    total++; if (dut.state_q !== S_AMOUNT) begin bad++; $display("FAIL abort_in_amount got=%0d exp=%0d", dut.state_q, S_AMOUNT); end
    bus.card = 1'b0; bus.amount = 2'b00;
    tick();
    total++; if (dut.state_q !== S_IDLE || outs() !== 6'b0) begin bad++; $display("FAIL abort_card state=%0d outs=%b exp_state=%0d", dut.state_q, outs(), S_IDLE); end
    total++; if (dut.bal_q !== BAL_W'(model_bal)) begin bad++; $display("FAIL abort_bal got=%0d exp=%0d", dut.bal_q, model_bal); end
  endtask

  task automatic test_reset_mid();
    logic [5:0] got, e; logic [2:0] st, es;
    // Reset while a pulse is on the outputs.
    drive_txn(1'b0, 2'b00, got, st);
    e = exp_q.pop_front(); es = exp_st_q.pop_front();
    total++; if (got !== e) begin bad++; $display("FAIL rstmid_pulse got=%b exp=%b", got, e); end
    #2 reset = 1'b0;
    #1;
    total++; if (outs() !== 6'b0) begin bad++; $display("FAIL rstmid_async_outs got=%b exp=%b", outs(), 6'b0); end
    total++; if (dut.bal_q !== BAL_W'(INIT_BALANCE)) begin bad++; $display("FAIL rstmid_bal got=%0d exp=%0d", dut.bal_q, INIT_BALANCE); end
    tick();
    reset = 1'b1;
    model_bal = INIT_BALANCE;
    tick();
    total++; if (dut.state_q !== S_PIN_WAIT) begin bad++; $display("FAIL rstmid_restart got=%0d exp=%0d", dut.state_q, S_PIN_WAIT); end
    // Reset while sitting in AMOUNT after a deposit moved the balance.
    bus.card = 1'b0;
    tick();
    drive_txn(1'b1, 2'b00, got, st);
    e = exp_q.pop_front(); es = exp_st_q.pop_front();
    end_txn();
    bus.card = 1'b1;
    tick();
    bus.PIN = 1'b1;
    tick();
    bus.PIN = 1'b0; bus.choice = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    total++; if (outs() !== 6'b0 || dut.state_q !== S_IDLE) begin bad++; $display("FAIL rst_amount state=%0d outs=%b exp_state=%0d", dut.state_q, outs(), S_IDLE); end
    total++; if (dut.bal_q !== BAL_W'(INIT_BALANCE)) begin bad++; $display("FAIL rst_amount_bal got=%0d exp=%0d", dut.bal_q, INIT_BALANCE); end
    tick();
    reset = 1'b1;
    bus.card = 1'b0;
    tick();
  endtask

  initial begin
    bus.card = 1'b0; bus.PIN = 1'b0; bus.choice = 1'b0; bus.amount = 2'b00;
    model_bal = INIT_BALANCE;
    test_reset();
    test_withdraw();
    test_insufficient();
    test_deposit();
    test_timeout();
    test_cancel();
    test_back_to_back();
    test_overflow();
    test_abort_card();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atm_dut.md
Name: atm_dut

Overview:
- Single-account ATM transaction controller.
- Sequences card insertion, PIN confirmation, withdraw/deposit choice and denomination selection.
- Tracks an internal balance in units of 50000 and emits one-cycle dispense (W_*) or accept (D_*) pulses.
- Sits between front-panel input logic and the cash-handling mechanism.

Parameters:
- BAL_W, 8: balance register width, in units of 50000.
- INIT_BALANCE, 4: balance loaded at reset, in units (4 = 200000).
- PIN_TIMEOUT, 16: cycles allowed in PIN_WAIT before the card is rejected.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- card  in  1  level; 1 = card present.
- PIN  in  1  1 = correct PIN confirmed (sampled in PIN_WAIT).
- choice  in  1  sampled in SELECT; 0 = withdraw, 1 = deposit.
- amount  in  2  sampled in AMOUNT; 00 = 50000 (1 unit), 01 = 100000 (2), 10 = 200000 (4), 11 = cancel.
- W_50000, W_100000, W_200000  out  1 each  withdraw dispense pulse for that denomination.
- D_50000, D_100000, D_200000  out  1 each  deposit accept pulse for that denomination.

Behaviour:
- Reset (reset = 0, async):
  - state = IDLE; all six outputs = 0; balance = INIT_BALANCE; timer = 0; op register = 0.
- All outputs are registered and are 0 in every state except DONE.
- At most one output is high in any cycle.
- States and transitions:
  - IDLE: card = 1 -> PIN_WAIT, timer cleared.
  - PIN_WAIT:
    - PIN = 1 -> SELECT.
    - Else if timer = PIN_TIMEOUT-1 -> EJECT.
    - Else timer increments.
  - SELECT: latch choice into op -> AMOUNT (exactly one cycle).
  - AMOUNT:
    - amount = 11 -> EJECT (cancel, no pulse, balance unchanged).
    - Withdraw with balance >= units -> DONE; balance -= units; set the matching W_* for the DONE cycle.
    - Withdraw with balance < units -> EJECT, no pulse.
    - Deposit with balance + units <= 2^BAL_W-1 -> DONE; balance += units; set the matching D_*.
    - Deposit that would overflow -> EJECT, no pulse.
  - DONE: output high for exactly this one cycle -> EJECT.
  - EJECT: outputs 0; card = 0 -> IDLE. Only one transaction per insertion.
- card = 0 in PIN_WAIT, SELECT or AMOUNT -> IDLE next edge, no pulse, balance unchanged.
  - Removal during DONE does not cancel the pulse already issued; the next state is IDLE.
- Latency: card sampled 1 at edge k; PIN = 1 at k+1; choice at k+2; amount at k+3; output high from k+3 until k+4.
- Balance persists across transactions; it is reset only by reset.
- Reset asserted mid-transaction:
  - outputs clear immediately (asynchronously);
  - balance returns to INIT_BALANCE;
  - FSM returns to IDLE, and a card still inserted after release starts a new transaction.

Test Plan:
- Reset then idle: reset = 0 for 2 cycles, release, card = 0 -> all outputs 0 indefinitely.
- Withdraw 100000: card = 1, PIN = 1, choice = 0, amount = 01 on successive cycles -> W_100000 high exactly one cycle at k+3; balance 4 -> 2; card = 0 returns FSM to IDLE.
- Insufficient funds: after reset, withdraw 200000 (succeeds, balance 0), remove card; reinsert and withdraw 50000 -> no W_* pulse, FSM in EJECT until card = 0.
- Deposit 200000: choice = 1, amount = 10 -> D_200000 one-cycle pulse; a subsequent withdraw 200000 succeeds.
- PIN timeout and cancel: card = 1, PIN = 0 for PIN_TIMEOUT cycles -> EJECT, no outputs; separate run with amount = 11 -> no outputs, balance unchanged.
- Abort paths: card dropped in AMOUNT -> IDLE, no pulse; reset = 0 asserted in AMOUNT -> outputs 0 immediately, balance = INIT_BALANCE.
